// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative shift-add multiplier owning the HI/LO registers,
// serving MULT/MULTU/MADD/MSUB/MUL plus MTHI/MTLO/MFHI/MFLO beside the EX-stage ALU.
module hilo_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [5:0] OP_MULT  = 6'b100100;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MADD  = 6'b000101;
    localparam logic [5:0] OP_MSUB  = 6'b100101;
    localparam logic [5:0] OP_MUL   = 6'b100011;
    localparam logic [5:0] OP_MTHI  = 6'b001101;
    localparam logic [5:0] OP_MTLO  = 6'b101101;
    localparam logic [5:0] OP_MFHI  = 6'b001110;
    localparam logic [5:0] OP_MFLO  = 6'b101110;

    typedef enum logic [1:0] {IDLE, MULT_RUN, FINISH} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand, acc, pp, prod, hilo_nx;
    logic [WIDTH-1:0]     mplier, mul_lo, abs_a, abs_b;
    logic [5:0]           op;
    logic                 neg, iter_code, sgn;

    always_comb begin
        iter_code = ALUControl inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL};
        sgn       = ALUControl != OP_MULTU;
        abs_a     = (sgn && A[WIDTH-1]) ? -A : A;
        abs_b     = (sgn && B[WIDTH-1]) ? -B : B;
        pp        = mcand * (2*WIDTH)'(mplier[BITS_PER_CYCLE-1:0]);
        prod      = neg ? -acc : acc;
        hilo_nx   = (op == OP_MADD) ? {Hi, Lo} + prod :
                    (op == OP_MSUB) ? {Hi, Lo} - prod : prod;
        state_nx  = (state == IDLE)     ? ((Start && iter_code) ? MULT_RUN : IDLE) :
                    (state == MULT_RUN) ? ((cnt == LAST) ? FINISH : MULT_RUN) : IDLE;
        Busy      = state != IDLE;
        Result    = (state == IDLE && ALUControl == OP_MFHI) ? Hi :
                    (state == IDLE && ALUControl == OP_MFLO) ? Lo : mul_lo;
    end

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_nx;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Hi     <= '0;
            Lo     <= '0;
            mul_lo <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            op     <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= state == FINISH;
            case (state)
                IDLE: if (Start) begin
                    if (iter_code) begin
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        op     <= ALUControl;
                    end else if (ALUControl == OP_MTHI) Hi <= A;
                    else if (ALUControl == OP_MTLO) Lo <= A;
                end
                MULT_RUN: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                end
                FINISH: begin
                    // MUL returns through Result only; HI/LO keep their architectural value
                    if (op == OP_MUL) mul_lo <= prod[WIDTH-1:0];
                    else {Hi, Lo} <= hilo_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors against a cycle-count/arithmetic reference model.
module tb_hilo_muldiv_unit;
    localparam logic [5:0] MULT = 6'b100100, MULTU = 6'b000100, MADD = 6'b000101,
                           MSUB = 6'b100101, MUL = 6'b100011, MTHI = 6'b001101,
                           MTLO = 6'b101101, MFHI = 6'b001110, MFLO = 6'b101110,
                           NOP = 6'b000000;

    logic        clk = 0, rst = 1, start = 0;
    logic [5:0]  ctl = NOP;
    logic [31:0] a = 0, b = 0, result, hi, lo;
    logic        busy, done;
    int          total = 0, bad = 0;

    logic [31:0] m_hi, m_lo, m_mullo;
    logic [63:0] m_p;
    logic [5:0]  m_op;
    int          m_rem;
    logic        m_done;

    hilo_muldiv_unit dut (
        .Clk(clk), .Reset(rst), .Start(start), .ALUControl(ctl), .A(a), .B(b),
        .Result(result), .Hi(hi), .Lo(lo), .Busy(busy), .Done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: an iterative op occupies 33 cycles after acceptance, then commits.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_mullo <= 0; m_rem <= 0; m_done <= 0; m_p <= 0; m_op <= NOP;
        end else begin
            m_done <= m_rem == 1;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    if (m_op == MUL) m_mullo <= m_p[31:0];
                    else if (m_op == MADD) {m_hi, m_lo} <= {m_hi, m_lo} + m_p;
                    else if (m_op == MSUB) {m_hi, m_lo} <= {m_hi, m_lo} - m_p;
                    else {m_hi, m_lo} <= m_p;
                end
            end else if (start) begin
                if (ctl inside {MULT, MULTU, MADD, MSUB, MUL}) begin
                    m_op  <= ctl;
                    m_p   <= (ctl == MULTU) ? {32'b0, a} * {32'b0, b}
                                            : longint'($signed(a)) * longint'($signed(b));
                    m_rem <= 33;
                end else if (ctl == MTHI) m_hi <= a;
                else if (ctl == MTLO) m_lo <= a;
            end
        end
    end

    always @(negedge clk)
        if (!rst) begin
            chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("result", result, (m_rem == 0 && ctl == MFHI) ? m_hi :
                                  (m_rem == 0 && ctl == MFLO) ? m_lo : m_mullo);
        end

    task automatic op(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y,
                      input logic [5:0] post);
        start = 1; ctl = code; a = x; b = y;
        @(posedge clk); #2;
        start = 0; ctl = post;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    int n;
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        // 1
        op(MULT, 32'hFFFFFFFD, 32'h7, NOP);
        wait_done(n);
        chk("t1_latency", n, 34);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFEB);
        // 2 (next op issued in the Done cycle)
        op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, NOP);
        wait_done(n);
        chk("t2u_hi", hi, 32'hFFFFFFFE);
        chk("t2u_lo", lo, 32'h1);
        op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, NOP);
        wait_done(n);
        chk("t2s_hi", hi, 32'h0);
        chk("t2s_lo", lo, 32'h1);
        // 3
        op(MTHI, 32'h0, 32'h0, NOP);
        op(MTLO, 32'h5, 32'h0, NOP);
        op(MADD, 32'h2, 32'h3, MFLO);
        wait_done(n);
        chk("t3_madd_hi", hi, 32'h0);
        chk("t3_madd_res", result, 32'hB);
        op(MSUB, 32'h4, 32'h4, MFHI);
        wait_done(n);
        chk("t3_msub_res", result, 32'hFFFFFFFF);
        chk("t3_msub_lo", lo, 32'hFFFFFFFB);
        // 4
        op(MUL, 32'h00010000, 32'h00010000, NOP);
        wait_done(n);
        chk("t4_mul0", result, 32'h0);
        chk("t4_hi", hi, 32'hFFFFFFFF);
        chk("t4_lo", lo, 32'hFFFFFFFB);
        op(MUL, 32'h7, 32'hFFFFFFFE, NOP);
        wait_done(n);
        chk("t4_mul1", result, 32'hFFFFFFF2);
        // 5
        op(MULT, 32'd6, 32'd7, NOP);
        repeat (3) @(negedge clk);
        op(MULTU, 32'd100, 32'd100, NOP);
        wait_done(n);
        chk("t5_hi", hi, 32'h0);
        chk("t5_lo", lo, 32'd42);
        op(MULT, 32'd5, 32'd5, NOP);
        repeat (10) @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_done", {31'b0, done}, 0);
        chk("t5_rst_hi", hi, 0);
        chk("t5_rst_lo", lo, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        op(MULT, 32'd3, 32'd3, NOP);
        wait_done(n);
        chk("t5_after_lo", lo, 32'd9);
        // 6
        op(MTHI, 32'h12345678, 32'h0, MFHI);
        @(negedge clk);
        chk("t6_mfhi", result, 32'h12345678);
        op(6'b111111, 32'hDEADBEEF, 32'h1, NOP);
        repeat (3) @(negedge clk);
        chk("t6_ill_busy", {31'b0, busy}, 0);
        chk("t6_ill_hi", hi, 32'h12345678);
        chk("t6_ill_lo", lo, 32'd9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
